// File: rtl/rv32i_dmem_pkg.sv
// Shared types and widths for the RV32i data-memory arbiter.
package rv32i_dmem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_BE_W   = 4;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOCK_C = 2'd1,
        LOCK_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/rv32i_dmem_arbiter_lock_timer.sv
// Lock-duration counter; expire_o flags the last cycle a lock may be held.
module rv32i_lock_timer #(
    parameter int LOCK_MAX = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (run_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expire_o = (r_cnt == CNT_W'(LOCK_MAX - 1));

endmodule

// File: rtl/rv32i_dmem_arbiter.sv
// Data-memory arbiter between core port C and debug/loader port D.
// Define DMEM_ARB_RR_EN for round-robin contests; default is fixed C priority.
module rv32i_dmem_arbiter
    import rv32i_dmem_pkg::*;
#(
    parameter int LOCK_MAX = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   c_req_i,
    input  logic                   d_req_i,
    input  logic                   c_we_i,
    input  logic                   d_we_i,
    input  logic [DMEM_ADDR_W-1:0] c_addr_i,
    input  logic [DMEM_ADDR_W-1:0] d_addr_i,
    input  logic [DMEM_DATA_W-1:0] c_wdata_i,
    input  logic [DMEM_DATA_W-1:0] d_wdata_i,
    input  logic [DMEM_BE_W-1:0]   c_be_i,
    input  logic [DMEM_BE_W-1:0]   d_be_i,
    input  logic                   c_lock_i,
    input  logic                   d_lock_i,
    output logic                   c_gnt_o,
    output logic                   d_gnt_o,
    output logic                   c_rvalid_o,
    output logic                   d_rvalid_o,
    output logic [DMEM_DATA_W-1:0] c_rdata_o,
    output logic [DMEM_DATA_W-1:0] d_rdata_o,
    output logic                   mem_en_o,
    output logic                   mem_we_o,
    output logic [DMEM_ADDR_W-1:0] mem_addr_o,
    output logic [DMEM_DATA_W-1:0] mem_wdata_o,
    output logic [DMEM_BE_W-1:0]   mem_be_o,
    input  logic [DMEM_DATA_W-1:0] mem_rdata_i
);

    arb_state_e r_state;
    arb_state_e w_next_state;
    owner_e     r_last_owner;
    owner_e     r_rd_owner;
    logic       w_c_gnt;
    logic       w_d_gnt;
    logic       w_expire;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_c_gnt      = 1'b0;
        w_d_gnt      = 1'b0;
        w_next_state = r_state;
        case (r_state)
            FREE: begin
                if (c_req_i && d_req_i) begin
`ifdef DMEM_ARB_RR_EN
                    w_c_gnt = (r_last_owner != OWN_C);
                    w_d_gnt = !w_c_gnt;
`else
                    w_c_gnt = 1'b1;
`endif
                end else begin
                    w_c_gnt = c_req_i;
                    w_d_gnt = d_req_i;
                end
                // A one-cycle budget leaves no room to hold a lock at all.
                if (LOCK_MAX > 1) begin
                    if (w_c_gnt && c_lock_i) begin
                        w_next_state = LOCK_C;
                    end else if (w_d_gnt && d_lock_i) begin
                        w_next_state = LOCK_D;
                    end
                end
            end
            LOCK_C: begin
                w_c_gnt = c_req_i;
                if (w_expire || (w_c_gnt && !c_lock_i)) begin
                    w_next_state = FREE;
                end
            end
            LOCK_D: begin
                w_d_gnt = d_req_i;
                if (w_expire || (w_d_gnt && !d_lock_i)) begin
                    w_next_state = FREE;
                end
            end
            default: w_next_state = FREE;
        endcase
        if (reset_i) begin
            w_c_gnt = 1'b0;
            w_d_gnt = 1'b0;
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (w_c_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = c_we_i;
            mem_addr_o  = c_addr_i;
            mem_wdata_o = c_wdata_i;
            mem_be_o    = c_be_i;
        end else if (w_d_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_be_o    = d_be_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= FREE;
            r_last_owner <= OWN_D;
            r_rd_owner   <= OWN_NONE;
        end else begin
            r_state <= w_next_state;
            if (w_c_gnt) begin
                r_last_owner <= OWN_C;
            end else if (w_d_gnt) begin
                r_last_owner <= OWN_D;
            end
            if (w_c_gnt && !c_we_i) begin
                r_rd_owner <= OWN_C;
            end else if (w_d_gnt && !d_we_i) begin
                r_rd_owner <= OWN_D;
            end else begin
                r_rd_owner <= OWN_NONE;
            end
        end
    end

    // The counter also ticks on the locking grant itself, so the lock spans
    // at most LOCK_MAX cycles including that grant.
    rv32i_lock_timer #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .run_i    ((r_state != FREE) || (w_next_state != FREE)),
        .clr_i    (w_next_state == FREE),
        .expire_o (w_expire)
    );

    assign c_gnt_o    = w_c_gnt;
    assign d_gnt_o    = w_d_gnt;
    assign c_rvalid_o = !reset_i && (r_rd_owner == OWN_C);
    assign d_rvalid_o = !reset_i && (r_rd_owner == OWN_D);
    assign c_rdata_o  = c_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;

    // last_owner is only steering in round-robin builds; it must always name a port.
    a_last_owner_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        r_last_owner != OWN_NONE);

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Randomized + directed bench for rv32i_dmem_arbiter against a cycle-level reference model.
module tb_rv32i_dmem_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, d_req, c_we, d_we, c_lock, d_lock;
    logic [31:0] c_addr, d_addr, c_wdata, d_wdata, mem_rdata;
    logic [3:0]  c_be, d_be;

    logic        c_gnt_o, d_gnt_o, c_rvalid_o, d_rvalid_o;
    logic [31:0] c_rdata_o, d_rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the lock (0 none, 1 C, 2 D), the cycle by
    // which it must be gone, the last grantee and the port owed read data.
    int m_lock     = 0;
    int m_deadline = 0;
    int m_last     = 2;
    int m_rd       = 0;
    int m_cycle    = 0;
    logic exp_c, exp_d, obs_c;

    rv32i_dmem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk_i(clk), .reset_i(rst),
        .c_req_i(c_req), .d_req_i(d_req), .c_we_i(c_we), .d_we_i(d_we),
        .c_addr_i(c_addr), .d_addr_i(d_addr), .c_wdata_i(c_wdata), .d_wdata_i(d_wdata),
        .c_be_i(c_be), .d_be_i(d_be), .c_lock_i(c_lock), .d_lock_i(d_lock),
        .c_gnt_o(c_gnt_o), .d_gnt_o(d_gnt_o), .c_rvalid_o(c_rvalid_o), .d_rvalid_o(d_rvalid_o),
        .c_rdata_o(c_rdata_o), .d_rdata_o(d_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", tag, m_cycle, got, exp);
        end
    endtask

    task automatic set_c(input logic req, we, lock, input logic [31:0] addr, wdata);
        c_req = req; c_we = we; c_lock = lock; c_addr = addr; c_wdata = wdata; c_be = 4'hf;
    endtask

    task automatic set_d(input logic req, we, lock, input logic [31:0] addr, wdata);
        d_req = req; d_we = we; d_lock = lock; d_addr = addr; d_wdata = wdata; d_be = 4'h3;
    endtask

    // Called just after a rising edge: compare this cycle's outputs, then advance the model.
    task automatic tick();
        logic        e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_crv, e_drv;
        #3;
        exp_c = 1'b0;
        exp_d = 1'b0;
        if (!rst) begin
            if (m_lock == 0) begin
                if (c_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
                    if (m_last == 1) exp_d = 1'b1; else exp_c = 1'b1;
`else
                    exp_c = 1'b1;
`endif
                end else begin
                    exp_c = c_req;
                    exp_d = d_req;
                end
            end else if (m_lock == 1) begin
                exp_c = c_req;
            end else begin
                exp_d = d_req;
            end
        end
        e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
        if (exp_c) begin
            e_we = c_we; e_addr = c_addr; e_wdata = c_wdata; e_be = c_be;
        end else if (exp_d) begin
            e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_be;
        end
        e_crv = !rst && (m_rd == 1);
        e_drv = !rst && (m_rd == 2);
        obs_c = c_gnt_o;
        check("c_gnt",     32'(c_gnt_o),    32'(exp_c));
        check("d_gnt",     32'(d_gnt_o),    32'(exp_d));
        check("mem_en",    32'(mem_en_o),   32'(exp_c | exp_d));
        check("mem_we",    32'(mem_we_o),   32'(e_we));
        check("mem_addr",  mem_addr_o,      e_addr);
        check("mem_wdata", mem_wdata_o,     e_wdata);
        check("mem_be",    32'(mem_be_o),   32'(e_be));
        check("c_rvalid",  32'(c_rvalid_o), 32'(e_crv));
        check("d_rvalid",  32'(d_rvalid_o), 32'(e_drv));
        check("c_rdata",   c_rdata_o,       e_crv ? mem_rdata : 32'h0);
        check("d_rdata",   d_rdata_o,       e_drv ? mem_rdata : 32'h0);
        @(posedge clk);
        if (rst) begin
            m_lock = 0; m_last = 2; m_rd = 0;
        end else begin
            m_rd = (exp_c && !c_we) ? 1 : (exp_d && !d_we) ? 2 : 0;
            if (exp_c) m_last = 1;
            else if (exp_d) m_last = 2;
            if (m_lock == 0) begin
                if (LOCK_MAX > 1 && exp_c && c_lock) begin
                    m_lock = 1; m_deadline = m_cycle + LOCK_MAX;
                end else if (LOCK_MAX > 1 && exp_d && d_lock) begin
                    m_lock = 2; m_deadline = m_cycle + LOCK_MAX;
                end
            end else if (m_cycle == m_deadline - 1) begin
                m_lock = 0;
            end else if ((m_lock == 1 && exp_c && !c_lock) || (m_lock == 2 && exp_d && !d_lock)) begin
                m_lock = 0;
            end
        end
        m_cycle++;
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        mem_rdata = 32'h0;
        set_c(1, 0, 0, 32'h10, 32'h0);
        set_d(1, 0, 0, 32'h20, 32'h0);
        @(posedge clk);
        #1;
        // Reset with both ports requesting, then the first contest.
        repeat (3) tick();
        rst = 1'b0;
        tick();
        repeat (4) tick();
        set_c(0, 0, 0, 32'h0, 32'h0);
        set_d(0, 0, 0, 32'h0, 32'h0);
        tick();

        // Read routing back to C.
        set_c(1, 0, 0, 32'h100, 32'h0);
        tick();
        set_c(0, 0, 0, 32'h0, 32'h0);
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rdata = 32'h0;

        // D read-modify-write under lock while C waits.
        set_d(1, 0, 1, 32'h200, 32'h0);
        tick();
        set_c(1, 0, 0, 32'h300, 32'h0);
        set_d(1, 1, 0, 32'h200, 32'h1);
        mem_rdata = 32'h12345678;
        tick();
        set_d(0, 0, 0, 32'h0, 32'h0);
        tick();
        set_c(0, 0, 0, 32'h0, 32'h0);
        tick();

        // Lock timeout: D locks then idles; C must get in after LOCK_MAX cycles.
        set_d(1, 1, 1, 32'h400, 32'h5);
        tick();
        set_d(0, 0, 0, 32'h0, 32'h0);
        set_c(1, 1, 0, 32'h404, 32'h6);
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_c && n < 8);
        check("timeout_wait", 32'(n), 32'(LOCK_MAX));
        set_c(0, 0, 0, 32'h0, 32'h0);
        tick();

        // Reset arriving one cycle after a locked C read.
        set_c(1, 0, 1, 32'h500, 32'h0);
        tick();
        set_c(0, 0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_d(1, 0, 0, 32'h600, 32'h0);
        tick();
        set_d(0, 0, 0, 32'h0, 32'h0);
        tick();

        // Random traffic; a pending request is held until the model says it was granted.
        for (int i = 0; i < 500; i++) begin
            if (!c_req || exp_c) begin
                set_c($urandom_range(0, 99) < 60, 1'($urandom), $urandom_range(0, 99) < 25,
                      $urandom, $urandom);
                c_be = 4'($urandom);
            end
            if (!d_req || exp_d) begin
                set_d($urandom_range(0, 99) < 60, 1'($urandom), $urandom_range(0, 99) < 25,
                      $urandom, $urandom);
                d_be = 4'($urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            mem_rdata = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
